// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg
//   Shared constants and types for the host-side debug unit:
//   - host command byte values (load, continuous run, single step, halt)
//   - top-level FSM state encoding
//   - cycle-counter width and bytes-per-word for stream assembly / reporting
package debug_unit_pkg;

    localparam int COUNT_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RUN,
        ST_STEP,
        ST_SEND
    } state_t;

endpackage

// File: rtl/dunit_tx_serializer.sv
// dunit_tx_serializer
//   Sends a COUNT_W-bit word MSB first as BYTES_PER_WORD bytes over a simple
//   ready/start transmitter handshake. For each byte: wait for i_tx_ready,
//   pulse o_tx_start for one cycle, idle one cycle (lets the transmitter drop
//   ready), then wait for ready again. o_done pulses once the last byte's
//   start has been issued.
// Ports:
//   i_clk, i_reset   clock, async active-high reset
//   i_word           word to send, captured on i_start
//   i_start          one-cycle request strobe (ignored while busy)
//   i_tx_ready       transmitter can accept a byte
//   o_tx_data        byte being sent, held stable until the next byte
//   o_tx_start       one-cycle transmit strobe
//   o_done           one-cycle completion pulse
module dunit_tx_serializer
    import debug_unit_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [COUNT_W-1:0] i_word,
    input  logic               i_start,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_done
);

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_WAIT,
        SER_PULSE,
        SER_GAP
    } ser_state_t;

    ser_state_t         state;
    logic [COUNT_W-1:0] shreg;
    logic [1:0]         byte_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= SER_IDLE;
            shreg      <= '0;
            byte_idx   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                SER_IDLE: begin
                    if (i_start) begin
                        shreg    <= i_word;
                        byte_idx <= '0;
                        state    <= SER_WAIT;
                    end
                end
                SER_WAIT: begin
                    if (i_tx_ready) begin
                        o_tx_data  <= shreg[COUNT_W-1 -: 8];
                        shreg      <= {shreg[COUNT_W-9:0], 8'h00};
                        o_tx_start <= 1'b1;
                        state      <= SER_PULSE;
                    end
                end
                // o_tx_start is high during this cycle
                SER_PULSE: begin
                    if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                        o_done <= 1'b1;
                        state  <= SER_IDLE;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        state    <= SER_GAP;
                    end
                end
                // transmitter needs a cycle to deassert ready after a start
                SER_GAP: state <= SER_WAIT;
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_unit.sv
// debug_unit
//   Host-side controller in front of the MIPS pipeline. Decodes a UART byte
//   stream: 'L' loads N program words into instruction memory, 'C' runs the
//   pipeline until HALT retires or 'H' arrives, 'S' steps one cycle. After a
//   run/step the 32-bit executed-cycle count is reported MSB first over UART.
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_rx_data/i_rx_valid  received byte and its one-cycle strobe
//   i_tx_ready            transmitter idle
//   i_halt                pipeline has retired HALT (level)
//   o_tx_data/o_tx_start  byte to send and its one-cycle strobe
//   o_dunit_clk_en        pipeline clock enable
//   o_dunit_w_en          instruction-memory write strobe
//   o_dunit_mem_addr      byte address of the write
//   o_dunit_mem_data      word to write
//   o_busy                high whenever the FSM is not in IDLE
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int NB_REG   = 32,
    parameter int NB_WIDHT = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_tx_ready,
    input  logic              i_halt,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_dunit_clk_en,
    output logic              o_dunit_w_en,
    output logic [NB_REG-1:0] o_dunit_mem_addr,
    output logic [NB_REG-1:0] o_dunit_mem_data,
    output logic              o_busy
);

    // first byte address past the end of instruction memory
    localparam logic [NB_REG-1:0] MEM_BYTES = NB_REG'(1) << NB_WIDHT;

    state_t             state;
    logic [COUNT_W-1:0] cycle_cnt;
    logic [7:0]         n_words;
    logic [7:0]         word_idx;
    logic [1:0]         byte_cnt;
    logic [NB_REG-1:0]  word_sr;
    logic               ser_start;
    logic               ser_done;

    logic [NB_REG-1:0]  wr_addr;
    logic [NB_REG-1:0]  wr_word;
    logic               rx_halt_cmd;

    // word index -> byte address (4 bytes per word)
    assign wr_addr     = NB_REG'({word_idx, 2'b00});
    assign wr_word     = {word_sr[NB_REG-9:0], i_rx_data};
    assign rx_halt_cmd = i_rx_valid && (i_rx_data == CMD_HALT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            cycle_cnt        <= '0;
            n_words          <= '0;
            word_idx         <= '0;
            byte_cnt         <= '0;
            word_sr          <= '0;
            ser_start        <= 1'b0;
            o_dunit_clk_en   <= 1'b0;
            o_dunit_w_en     <= 1'b0;
            o_dunit_mem_addr <= '0;
            o_dunit_mem_data <= '0;
            o_busy           <= 1'b0;
        end else begin
            o_dunit_w_en <= 1'b0;
            ser_start    <= 1'b0;

            // counts every cycle the pipeline actually advanced
            if (o_dunit_clk_en)
                cycle_cnt <= cycle_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                cycle_cnt <= '0;
                                word_idx  <= '0;
                                o_busy    <= 1'b1;
                                state     <= ST_LOAD_CNT;
                            end
                            CMD_RUN: begin
                                o_busy <= 1'b1;
                                if (i_halt) begin
                                    ser_start <= 1'b1;
                                    state     <= ST_SEND;
                                end else begin
                                    o_dunit_clk_en <= 1'b1;
                                    state          <= ST_RUN;
                                end
                            end
                            CMD_STEP: begin
                                o_busy <= 1'b1;
                                if (i_halt) begin
                                    ser_start <= 1'b1;
                                    state     <= ST_SEND;
                                end else begin
                                    o_dunit_clk_en <= 1'b1;
                                    state          <= ST_STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_LOAD_CNT: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == 8'd0) begin
                            o_busy <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            n_words  <= i_rx_data;
                            byte_cnt <= '0;
                            state    <= ST_LOAD_BYTE;
                        end
                    end
                end

                ST_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        word_sr <= wr_word;
                        if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                            byte_cnt <= '0;
                            state    <= ST_LOAD_WRITE;
                            // out-of-range words are consumed but never written
                            if (wr_addr < MEM_BYTES) begin
                                o_dunit_w_en     <= 1'b1;
                                o_dunit_mem_addr <= wr_addr;
                                o_dunit_mem_data <= wr_word;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                // write strobe is visible this cycle; rx bytes here are dropped
                ST_LOAD_WRITE: begin
                    word_idx <= word_idx + 8'd1;
                    if (word_idx + 8'd1 == n_words) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state <= ST_LOAD_BYTE;
                    end
                end

                // halt and 'H' in the same cycle collapse into one stop
                ST_RUN: begin
                    if (i_halt || rx_halt_cmd) begin
                        o_dunit_clk_en <= 1'b0;
                        ser_start      <= 1'b1;
                        state          <= ST_SEND;
                    end else begin
                        o_dunit_clk_en <= 1'b1;
                    end
                end

                // single enabled cycle is this one
                ST_STEP: begin
                    o_dunit_clk_en <= 1'b0;
                    ser_start      <= 1'b1;
                    state          <= ST_SEND;
                end

                // serializer captures the counter one cycle after ser_start,
                // by which point the final increment has landed
                ST_SEND: begin
                    if (ser_done) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: begin
                    o_dunit_clk_en <= 1'b0;
                    o_busy         <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

    dunit_tx_serializer u_tx_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_word     (cycle_cnt),
        .i_start    (ser_start),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (ser_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit
//   Directed bench for debug_unit: reset, load, step, continuous run, halted
//   step, 'H' abort, memory overflow, tx backpressure and mid-load reset.
module tb_debug_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready;
    logic        halt = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        clk_en;
    logic        w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // transmitter model: busy for 3 cycles after each start, plus forced hold
    logic tx_hold = 1'b0;
    int   tx_busy_cnt = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];
    int          clken_cnt = 0;

    always #5 clk = ~clk;

    assign tx_ready = !tx_hold && (tx_busy_cnt == 0);

    always @(posedge clk) begin
        if (tx_start)             tx_busy_cnt <= 3;
        else if (tx_busy_cnt != 0) tx_busy_cnt <= tx_busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (w_en) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
        if (clk_en)   clken_cnt++;
        if (tx_start) tx_q.push_back(tx_data);
    end

    debug_unit #(.NB_REG(32), .NB_WIDHT(9)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_rx_data        (rx_data),
        .i_rx_valid       (rx_valid),
        .i_tx_ready       (tx_ready),
        .i_halt           (halt),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start),
        .o_dunit_clk_en   (clk_en),
        .o_dunit_w_en     (w_en),
        .o_dunit_mem_addr (mem_addr),
        .o_dunit_mem_data (mem_data),
        .o_busy           (busy)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // strobe occupies the current cycle; returns 1ns into the next one
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] tx_word(input int base);
        if (tx_q.size() >= base + 4)
            return {tx_q[base], tx_q[base+1], tx_q[base+2], tx_q[base+3]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %0b want 0", clk_en); end
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %0b want 0", w_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h want 0", mem_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_load();
        logic [7:0] w0 [4] = '{8'h20, 8'h01, 8'h00, 8'h05};
        logic [7:0] w1 [4] = '{8'h8C, 8'h02, 8'h00, 8'h04};
        int wb;
        wb = wr_addr_q.size();
        send_byte(8'h4C);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_on_L: got %0b want 1", busy); end
        idle(1);
        send_byte(8'h02); idle(1);
        for (int i = 0; i < 4; i++) begin
            send_byte(w0[i]);
            if (i < 3) idle(1);
        end
        checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL load_w0_wen: got %0b want 1", w_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL load_w0_addr: got %0h want 0", mem_addr); end
        checks++; if (mem_data !== 32'h2001_0005) begin errors++; $display("FAIL load_w0_data: got %0h want 20010005", mem_data); end
        idle(1);
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL load_w0_wen_drop: got %0b want 0", w_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_mid: got %0b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            send_byte(w1[i]);
            if (i < 3) idle(1);
        end
        checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL load_w1_wen: got %0b want 1", w_en); end
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL load_w1_addr: got %0h want 4", mem_addr); end
        checks++; if (mem_data !== 32'h8C02_0004) begin errors++; $display("FAIL load_w1_data: got %0h want 8c020004", mem_data); end
        idle(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_end: got %0b want 0", busy); end
        checks++; if (wr_addr_q.size() - wb != 2) begin errors++; $display("FAIL load_write_count: got %0d want 2", wr_addr_q.size() - wb); end
    endtask

    task automatic test_step();
        int cb, tb;
        bit ok;
        halt = 1'b0;
        cb = clken_cnt;
        tb = tx_q.size();
        send_byte(8'h53);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL step_clk_en_on: got %0b want 1", clk_en); end
        idle(1);
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL step_clk_en_off: got %0b want 0", clk_en); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL step_timeout: busy stuck got 1 want 0"); end
        checks++; if (clken_cnt - cb != 1) begin errors++; $display("FAIL step_enabled_cycles: got %0d want 1", clken_cnt - cb); end
        checks++; if (tx_word(tb) !== 32'h0000_0001) begin errors++; $display("FAIL step_tx_count: got %0h want 00000001", tx_word(tb)); end
    endtask

    task automatic test_run();
        int cb, tb;
        bit ok;
        // L with N=0 clears the counter and returns at once
        send_byte(8'h4C); idle(1);
        send_byte(8'h00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_load_n0_busy: got %0b want 0", busy); end
        idle(1);
        cb = clken_cnt;
        tb = tx_q.size();
        send_byte(8'h43);
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL run_clk_en_start: got %0b want 1", clk_en); end
        idle(36);
        halt = 1'b1;  // 37th enabled cycle
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL run_clk_en_at_halt: got %0b want 1", clk_en); end
        idle(1);
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL run_clk_en_drop: got %0b want 0", clk_en); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL run_tx_start_early: got %0b want 0", tx_start); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL run_timeout: busy stuck got 1 want 0"); end
        checks++; if (clken_cnt - cb != 37) begin errors++; $display("FAIL run_enabled_cycles: got %0d want 37", clken_cnt - cb); end
        checks++; if (tx_word(tb) !== 32'h0000_0025) begin errors++; $display("FAIL run_tx_count: got %0h want 00000025", tx_word(tb)); end

        // step while halted: no enable, count unchanged
        idle(2);
        cb = clken_cnt;
        tb = tx_q.size();
        send_byte(8'h53);
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL halted_step_clk_en: got %0b want 0", clk_en); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL halted_step_timeout: busy stuck got 1 want 0"); end
        checks++; if (clken_cnt != cb) begin errors++; $display("FAIL halted_step_cycles: got %0d want 0", clken_cnt - cb); end
        checks++; if (tx_word(tb) !== 32'h0000_0025) begin errors++; $display("FAIL halted_step_tx: got %0h want 00000025", tx_word(tb)); end
        halt = 1'b0;
        idle(2);
    endtask

    task automatic test_halt_abort();
        int cb, tb;
        bit ok;
        send_byte(8'h4C); idle(1);
        send_byte(8'h00); idle(1);
        cb = clken_cnt;
        tb = tx_q.size();
        send_byte(8'h43);
        idle(9);
        send_byte(8'h48);  // strobe during 10th enabled cycle
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL abort_clk_en_drop: got %0b want 0", clk_en); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: busy stuck got 1 want 0"); end
        checks++; if (clken_cnt - cb != 10) begin errors++; $display("FAIL abort_enabled_cycles: got %0d want 10", clken_cnt - cb); end
        checks++; if (tx_word(tb) !== 32'h0000_000A) begin errors++; $display("FAIL abort_tx_count: got %0h want 0000000a", tx_word(tb)); end
        idle(2);
    endtask

    task automatic test_overflow();
        int wb, bad;
        logic [7:0]  wl;
        logic [31:0] exp_w;
        wb = wr_addr_q.size();
        send_byte(8'h4C); idle(1);
        send_byte(8'd130); idle(1);
        for (int w = 0; w < 130; w++) begin
            wl = w[7:0];
            exp_w = {wl, 8'hA5, ~wl, 8'h3C};
            for (int b = 0; b < 4; b++) begin
                send_byte(exp_w[31 - 8*b -: 8]);
                idle(1);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overflow_busy_end: got %0b want 0", busy); end
        checks++; if (wr_addr_q.size() - wb != 128) begin errors++; $display("FAIL overflow_write_count: got %0d want 128", wr_addr_q.size() - wb); end
        bad = 0;
        if (wr_addr_q.size() - wb == 128) begin
            for (int w = 0; w < 128; w++) begin
                wl = w[7:0];
                exp_w = {wl, 8'hA5, ~wl, 8'h3C};
                if (wr_addr_q[wb+w] !== 32'(w*4) || wr_data_q[wb+w] !== exp_w) bad++;
            end
        end else begin
            bad = 1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL overflow_addr_data: got %0d bad writes want 0", bad); end
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[$] !== 32'h1FC) begin errors++; $display("FAIL overflow_last_addr: got %0h want 1fc", (wr_addr_q.size() == 0) ? 32'h0 : wr_addr_q[$]); end
        idle(2);
    endtask

    task automatic test_backpressure();
        int tb;
        bit ok;
        halt = 1'b0;
        tx_hold = 1'b1;
        tb = tx_q.size();
        send_byte(8'h53);
        idle(20);
        checks++; if (tx_q.size() != tb) begin errors++; $display("FAIL bp_no_start: got %0d starts want 0", tx_q.size() - tb); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_held: got %0b want 1", busy); end
        tx_hold = 1'b0;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy stuck got 1 want 0"); end
        checks++; if (tx_word(tb) !== 32'h0000_0001) begin errors++; $display("FAIL bp_tx_count: got %0h want 00000001", tx_word(tb)); end
        idle(2);
    endtask

    task automatic test_reset_midload();
        logic [7:0] d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int wb;
        send_byte(8'h4C); idle(1);
        send_byte(8'h03); idle(1);
        for (int i = 0; i < 6; i++) begin
            send_byte(d[i]);
            idle(1);
        end
        #3 rst = 1'b1;  // asynchronous, mid-cycle
        #1;
        checks++; if ({tx_data, tx_start, clk_en, w_en, mem_addr, mem_data, busy} !== '0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got w_en=%0b addr=%0h data=%0h busy=%0b want all 0", w_en, mem_addr, mem_data, busy);
        end
        idle(2);
        rst = 1'b0;
        idle(1);
        wb = wr_addr_q.size();
        // leftover payload arrives in IDLE and must be ignored
        send_byte(8'h77); idle(1);
        send_byte(8'h88); idle(3);
        checks++; if (wr_addr_q.size() != wb) begin errors++; $display("FAIL midload_no_wen: got %0d writes want 0", wr_addr_q.size() - wb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midload_idle: got busy %0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_run();
        test_halt_abort();
        test_overflow();
        test_backpressure();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side control block sitting directly upstream of the MIPS pipeline top. It consumes a byte stream from a UART receiver and loads program words into instruction memory through the pipeline's data-unit write port. It gates pipeline execution through the data-unit clock enable, in either continuous or single-step mode. After each run or step it reports the executed-cycle count back through a UART transmitter.

## Interface
Parameters:
- NB_REG, 32, width of instruction word and data-unit address/data buses
- NB_WIDHT, 9, byte-address width of instruction memory (capacity 2^NB_WIDHT bytes = 128 words at default)

Ports:
- i_clk  in  1  system clock; one clock domain
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_tx_ready  in  1  transmitter idle, may accept a byte
- i_halt  in  1  pipeline has retired HALT (level)
- o_tx_data  out  8  byte to transmit, held stable while sending
- o_tx_start  out  1  one-cycle transmit strobe
- o_dunit_clk_en  out  1  pipeline clock enable (to i_dunit_clk_en)
- o_dunit_w_en  out  1  instruction-memory write strobe (to i_dunit_w_en)
- o_dunit_mem_addr  out  NB_REG  byte address of write
- o_dunit_mem_data  out  NB_REG  word to write
- o_busy  out  1  high in every state except IDLE

## Operation
- Commands, decoded in IDLE only: 'L' 0x4C load, 'C' 0x43 continuous run, 'S' 0x53 step. Other bytes in IDLE are ignored.
- Load:
  - 'L' clears the cycle counter and the word index, then goes to LOAD_CNT.
  - Next byte N is the word count. N=0 returns to IDLE with no writes.
  - Then 4N bytes follow, MSB first, in LOAD_BYTE.
  - Each 4th byte completes a word. In LOAD_WRITE, o_dunit_w_en pulses for one cycle with addr = index*4 and data = the assembled word, and the index increments.
  - Writes whose addr ≥ 2^NB_WIDHT are suppressed (no w_en), but their bytes are still consumed.
  - After word N the block returns to IDLE. It sends no reply.
- Run ('C'):
  - In RUN, o_dunit_clk_en = ~i_halt, and the counter increments on each cycle with clk_en high.
  - RUN exits to SEND when i_halt rises or when an 'H' (0x48) byte is received.
  - If i_halt is already high on entry, the block runs zero cycles and goes straight to SEND.
- Step ('S'):
  - If i_halt is low: STEP asserts clk_en for exactly one cycle, increments the counter, then goes to SEND.
  - If i_halt is high: no clk_en, go to SEND.
- Send:
  - Transmits the 32-bit counter MSB first as 4 bytes.
  - Per byte: wait for i_tx_ready=1, pulse o_tx_start for 1 cycle, wait 1 cycle, then wait for i_tx_ready=1 before the next byte.
  - After the 4th byte, return to IDLE.
- rx bytes arriving in SEND, STEP, or LOAD_WRITE are dropped. In RUN, only 'H' is honoured.
- Counter width 32, wraps modulo 2^32. It is not cleared by C/S, so it accumulates across runs until the next 'L' or reset.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, SEND.

## Timing
- All outputs are registered. Reset values: o_tx_data=0, o_tx_start=0, o_dunit_clk_en=0, o_dunit_w_en=0, o_dunit_mem_addr=0, o_dunit_mem_data=0, o_busy=0. Reset also sets state=IDLE and counter=0.
- Reset asserted mid-load or mid-run aborts immediately. Partially assembled words are discarded and no further w_en is issued.
- 4th byte strobe at cycle t → o_dunit_w_en=1 at t+1, with addr/data valid in the same cycle; w_en=0 at t+2.
- 'C' strobe at t → clk_en=1 from t+1.
- i_halt high at cycle t → clk_en=0 at t+1, and first o_tx_start no earlier than t+2.
- 'H' strobe at t → clk_en=0 at t+1.
- i_halt and 'H' arriving in the same cycle are treated as a single stop.
- Step: clk_en high for exactly one cycle.

## Structure
- Package debug_unit_pkg holds:
  - command byte constants (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_HALT)
  - the state enum
  - COUNT_W=32
  - BYTES_PER_WORD=4
- One natural sub-module, dunit_tx_serializer: takes a 32-bit word plus a start strobe, runs the 4-byte MSB-first tx handshake, and returns a done pulse.

## Test plan
- Load: 'L', N=2, bytes 20 01 00 05 / 8C 02 00 04 → w_en pulses twice; addr 0 data 0x20010005, then addr 4 data 0x8C020004; busy falls after the 2nd write.
- Step: 'S' with i_halt=0 → clk_en high for exactly 1 cycle; tx sends 00 00 00 01.
- Continuous run: 'C', i_halt raised after 37 enabled cycles → clk_en drops the next cycle; tx sends 00 00 00 25.
- Overflow: 'L', N=130 → exactly 128 w_en pulses (last addr 0x1FC); all 520 bytes consumed; block back in IDLE.
- Halted and abort cases:
  - 'S' with i_halt=1 → no clk_en; tx reports the unchanged count.
  - 'C' then 'H' after 10 cycles → tx sends 00 00 00 0A.
- Reset and tx backpressure:
  - Reset mid-load after 6 bytes → no w_en, all outputs 0.
  - Hold i_tx_ready low during SEND → o_tx_start not issued until ready returns.
